hls_macc_lock_nch: RTL and testbench

Parametrised, logic-locked, multi-channel multiply-accumulate core with HLS `ap_ctrl_hs` block control. It is the successor of the fixed four-output locked MACC: channel count, data width and key mask are parameters. The working key is loaded serially at run time instead of being hard-wired, and a per-run mode selects accumulate or clear. It sits in the locking test harness, where a wrapper either drives the golden key or applies wrong keys for corruption measurements.

---
 rtl/hls_macc_lock_nch.sv | 207 ++++++++++++++++++++
 tb/tb_hls_macc_lock_nch.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_macc_lock_nch.sv
// ---------------------------------------------------------------------------
// hls_macc_lock_nch
//
// Logic-locked, multi-channel multiply-accumulate core with HLS ap_ctrl_hs
// block control. A run snapshots N_CH operand pairs. It then walks the
// channels one per cycle through a single shared multiplier. Each product
// either accumulates into the channel register or replaces it.
//
// Both operands are XOR-tweaked with (key_reg ^ KEY_MASK) before they are
// multiplied. With the golden key loaded the tweak is zero and the results
// are correct. Any other key corrupts the results without any indication.
//
// Ports
//   ap_clk, ap_rst    : clock (rising edge), synchronous active-high reset
//   ap_start          : level start request, sampled in IDLE
//   ap_done, ap_ready : one-cycle pulse at run completion
//   ap_idle           : high while the FSM sits in IDLE
//   mode              : 0 = accumulate, 1 = overwrite with product
//   i_a, i_b          : packed operands, channel c at [c*DATA_W +: DATA_W]
//   key_load, key_bit : serial key shift-in, MSB first
//   key_valid         : exactly KEY_W (or more) bits shifted in this load
//   o                 : packed per-channel result registers
//   o_ap_vld          : per-channel one-cycle valid pulse
// ---------------------------------------------------------------------------
module hls_macc_lock_nch #(
    parameter int                  DATA_W   = 32,
    parameter int                  N_CH     = 4,
    parameter logic [2*DATA_W-1:0] KEY_MASK = (2*DATA_W)'(64'hA5A5_5A5A_C3C3_3C3C)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    input  logic                     mode,
    input  logic [N_CH*DATA_W-1:0]   i_a,
    input  logic [N_CH*DATA_W-1:0]   i_b,
    input  logic                     key_load,
    input  logic                     key_bit,
    output logic                     key_valid,
    output logic [N_CH*DATA_W-1:0]   o,
    output logic [N_CH-1:0]          o_ap_vld
);

    localparam int KEY_W = 2 * DATA_W;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(KEY_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEYLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CH_W-1:0]        ch;
    logic                   mode_q;
    logic [KEY_W-1:0]       key_reg;
    logic [CNT_W-1:0]       key_cnt;
    logic                   key_valid_q;
    logic                   key_first;

    logic [DATA_W-1:0]      a_q [N_CH];
    logic [DATA_W-1:0]      b_q [N_CH];
    logic [DATA_W-1:0]      acc [N_CH];
    logic [N_CH-1:0]        vld_q;

    logic [KEY_W-1:0]       tweak;
    logic [DATA_W-1:0]      a_sel;
    logic [DATA_W-1:0]      b_sel;
    logic [DATA_W-1:0]      acc_sel;
    logic [DATA_W-1:0]      a_tw;
    logic [DATA_W-1:0]      b_tw;
    logic [DATA_W-1:0]      prod;
    logic [DATA_W-1:0]      acc_next;

    logic                   start_run;

    // A start is honoured only from IDLE, and only when no key load competes
    // for the same cycle (a key load wins).
    assign start_run = (state == S_IDLE) && !key_load && ap_start;

    // The tweak is zero with the golden key. It cannot change during a run
    // because key_reg only shifts in KEYLD.
    assign tweak = key_reg ^ KEY_MASK;

    // Shared datapath: pick the current channel's snapshot and accumulator,
    // tweak the operands, multiply mod 2^DATA_W, then accumulate or overwrite.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        acc_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch == CH_W'(c)) begin
                a_sel   = a_q[c];
                b_sel   = b_q[c];
                acc_sel = acc[c];
            end
        end
        a_tw     = a_sel ^ tweak[DATA_W-1:0];
        b_tw     = b_sel ^ tweak[KEY_W-1:DATA_W];
        prod     = a_tw * b_tw;
        acc_next = mode_q ? prod : (acc_sel + prod);
    end

    // Control FSM plus the key shift register. The key only moves in KEYLD.
    // The first shifted bit of each load restarts the count. The count
    // saturates at KEY_W, so extra bits keep shifting while key_valid stays
    // high.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= S_IDLE;
            ch          <= '0;
            mode_q      <= 1'b0;
            key_reg     <= '0;
            key_cnt     <= '0;
            key_valid_q <= 1'b0;
            key_first   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_load) begin
                        state     <= S_KEYLD;
                        key_first <= 1'b1;
                    end else if (ap_start) begin
                        state  <= S_RUN;
                        ch     <= '0;
                        mode_q <= mode;
                    end
                end
                S_KEYLD: begin
                    if (key_load) begin
                        key_reg <= {key_reg[KEY_W-2:0], key_bit};
                        if (key_first) begin
                            key_first   <= 1'b0;
                            key_cnt     <= CNT_W'(1);
                            key_valid_q <= 1'b0;
                        end else if (key_cnt != CNT_W'(KEY_W)) begin
                            key_cnt <= key_cnt + CNT_W'(1);
                            if (key_cnt == CNT_W'(KEY_W - 1)) begin
                                key_valid_q <= 1'b1;
                            end
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (ch == CH_W'(N_CH - 1)) begin
                        state <= S_DONE;
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand snapshot, per-channel accumulators and valid pulses. The
    // accumulator is the result register itself. o_ap_vld is a registered
    // one-hot of the channel written on the previous edge.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                a_q[c] <= '0;
                b_q[c] <= '0;
                acc[c] <= '0;
            end
            vld_q <= '0;
        end else begin
            vld_q <= '0;
            if (start_run) begin
                for (int c = 0; c < N_CH; c++) begin
                    a_q[c] <= i_a[c*DATA_W +: DATA_W];
                    b_q[c] <= i_b[c*DATA_W +: DATA_W];
                end
            end
            if (state == S_RUN) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (ch == CH_W'(c)) begin
                        acc[c]   <= acc_next;
                        vld_q[c] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign o[g*DATA_W +: DATA_W] = acc[g];
    end

    assign o_ap_vld  = vld_q;
    assign key_valid = key_valid_q;
    assign ap_idle   = (state == S_IDLE);
    assign ap_done   = (state == S_DONE);
    assign ap_ready  = (state == S_DONE);

endmodule

// File: tb/tb_hls_macc_lock_nch.sv
// ---------------------------------------------------------------------------
// tb_hls_macc_lock_nch
//
// Self-checking bench for hls_macc_lock_nch. The main instance uses the
// default parameters. A second instance (N_CH=1, DATA_W=8) covers the small
// parameter point. Expected channel results come from a bench-side model.
// They are queued at start time and popped as each o_ap_vld pulse appears.
// ---------------------------------------------------------------------------
module tb_hls_macc_lock_nch;

    localparam logic [63:0] GOLD   = 64'hA5A5_5A5A_C3C3_3C3C;
    localparam logic [15:0] GOLD_S = 16'h3C3C;

    typedef struct {
        int          ch;
        logic [31:0] val;
    } exp_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_start, ap_done, ap_idle, ap_ready;
    logic          mode;
    logic [127:0]  i_a, i_b, o;
    logic          key_load, key_bit, key_valid;
    logic [3:0]    o_ap_vld;

    logic          start_s, done_s, idle_s, ready_s, mode_s;
    logic [7:0]    a_s, b_s, o_s;
    logic          key_load_s, key_bit_s, key_valid_s;
    logic [0:0]    vld_s;

    int            tests_run    = 0;
    int            tests_failed = 0;

    exp_t          exp_q[$];
    logic [7:0]    exp2_q[$];
    logic [63:0]   key_m;
    int            cnt_m;
    logic          valid_m;
    logic [31:0]   acc_m [4];
    logic [7:0]    acc2_m;
    int            gold_res [4] = '{20, 30, 40, 50};

    logic [127:0]  a_base = {32'd5, 32'd4, 32'd3, 32'd2};
    logic [127:0]  b_base = {4{32'd10}};

    hls_macc_lock_nch dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .mode      (mode),
        .i_a       (i_a),
        .i_b       (i_b),
        .key_load  (key_load),
        .key_bit   (key_bit),
        .key_valid (key_valid),
        .o         (o),
        .o_ap_vld  (o_ap_vld)
    );

    hls_macc_lock_nch #(
        .DATA_W   (8),
        .N_CH     (1),
        .KEY_MASK (GOLD_S)
    ) dut_s (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start  (start_s),
        .ap_done   (done_s),
        .ap_idle   (idle_s),
        .ap_ready  (ready_s),
        .mode      (mode_s),
        .i_a       (a_s),
        .i_b       (b_s),
        .key_load  (key_load_s),
        .key_bit   (key_bit_s),
        .key_valid (key_valid_s),
        .o         (o_s),
        .o_ap_vld  (vld_s)
    );

    always #5 ap_clk = ~ap_clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expected entry.
    always @(negedge ap_clk) begin
        if (ap_rst === 1'b0) begin
            for (int c = 0; c < 4; c++) begin
                if (o_ap_vld[c] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("sb_unexpected_vld", 128'(c), 128'hFFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput($sformatf("sb_ch%0d_idx", c), 128'(c), 128'(e.ch));
                        checkOutput($sformatf("sb_ch%0d_val", c), 128'(o[c*32 +: 32]), 128'(e.val));
                    end
                end
            end
        end
    end

    // Model of one run: tweak, multiply mod 2^32, accumulate or overwrite.
    task automatic pushExpected(input logic m, input logic [127:0] a_pk, input logic [127:0] b_pk);
        logic [63:0] t;
        logic [31:0] at, bt, p;
        exp_t        e;
        t = key_m ^ GOLD;
        for (int c = 0; c < 4; c++) begin
            at = a_pk[c*32 +: 32] ^ t[31:0];
            bt = b_pk[c*32 +: 32] ^ t[63:32];
            p  = at * bt;
            acc_m[c] = m ? p : (acc_m[c] + p);
            e.ch  = c;
            e.val = acc_m[c];
            exp_q.push_back(e);
        end
    endtask

    // Serial key load. The first edge only moves IDLE->KEYLD, then nbits are
    // shifted in MSB first from key. With with_start, ap_start is raised
    // alongside key_load to check that the key load wins.
    task automatic loadKey(input logic [63:0] key, input int nbits, input logic with_start);
        key_load = 1'b1;
        if (with_start) ap_start = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            @(negedge ap_clk);
            key_bit = key[63 - i];
            key_m   = {key_m[62:0], key[63 - i]};
            if (i == 0) begin
                cnt_m   = 1;
                valid_m = 1'b0;
            end else if (cnt_m < 64) begin
                cnt_m++;
                if (cnt_m == 64) valid_m = 1'b1;
            end
            if (with_start && i == 0) begin
                ap_start = 1'b0;
                checkOutput("prio_not_idle", 128'(ap_idle), 128'd0);
            end
            if (with_start && i == 1) checkOutput("prio_no_vld", 128'(o_ap_vld), 128'd0);
        end
        @(negedge ap_clk);
        key_load = 1'b0;
        @(negedge ap_clk);
        checkOutput("key_valid", 128'(key_valid), 128'(valid_m));
        checkOutput("key_idle", 128'(ap_idle), 128'd1);
    endtask

    // One full run with cycle-accurate control checks. Operands are changed
    // right after the snapshot edge. Optionally key_load is held during the run.
    task automatic applyStimulus(input logic m, input logic [127:0] a_pk, input logic [127:0] b_pk,
                                 input logic key_during);
        pushExpected(m, a_pk, b_pk);
        ap_start = 1'b1;
        mode     = m;
        i_a      = a_pk;
        i_b      = b_pk;
        for (int k = 0; k <= 5; k++) begin
            @(negedge ap_clk);
            if (k == 0) begin
                ap_start = 1'b0;
                mode     = ~m;
                i_a      = ~a_pk;
                i_b      = ~b_pk;
                checkOutput("idle_fall", 128'(ap_idle), 128'd0);
                if (key_during) begin
                    key_load = 1'b1;
                    key_bit  = 1'b1;
                end
            end else if (k <= 4) begin
                checkOutput($sformatf("vld_cycle%0d", k), 128'(o_ap_vld), 128'(4'b0001 << (k - 1)));
                checkOutput($sformatf("done_cycle%0d", k), 128'(ap_done), 128'(k == 4));
                checkOutput($sformatf("ready_cycle%0d", k), 128'(ap_ready), 128'(k == 4));
                if (k == 4) key_load = 1'b0;
            end else begin
                checkOutput("idle_back", 128'(ap_idle), 128'd1);
                checkOutput("done_cleared", 128'(ap_done), 128'd0);
            end
        end
    endtask

    // Back-to-back runs on the 1-channel, 8-bit instance with ap_start held high.
    task automatic sweepRun(input logic m, input logic [7:0] a, input logic [7:0] b, input int n);
        logic [7:0] p, v;
        for (int r = 0; r < n; r++) begin
            p      = a * b;
            acc2_m = m ? p : (acc2_m + p);
            exp2_q.push_back(acc2_m);
        end
        start_s = 1'b1;
        mode_s  = m;
        a_s     = a;
        b_s     = b;
        for (int k = 0; k < 3 * n; k++) begin
            @(negedge ap_clk);
            if (k == 3 * (n - 1)) start_s = 1'b0;
            checkOutput($sformatf("sw_done_k%0d", k), 128'(done_s), 128'((k % 3) == 1));
            checkOutput($sformatf("sw_vld_k%0d", k), 128'(vld_s), 128'((k % 3) == 1));
            if ((k % 3) == 1) begin
                if (exp2_q.size() == 0) begin
                    checkOutput("sw_queue_empty", 128'd1, 128'd0);
                end else begin
                    v = exp2_q.pop_front();
                    checkOutput($sformatf("sw_o_k%0d", k), 128'(o_s), 128'(v));
                end
            end
            if ((k % 3) == 2) checkOutput($sformatf("sw_idle_k%0d", k), 128'(idle_s), 128'd1);
        end
    endtask

    initial begin
        ap_rst = 1'b1; ap_start = 1'b0; mode = 1'b0; i_a = '0; i_b = '0;
        key_load = 1'b0; key_bit = 1'b0;
        start_s = 1'b0; mode_s = 1'b0; a_s = '0; b_s = '0;
        key_load_s = 1'b0; key_bit_s = 1'b0;
        key_m = '0; cnt_m = 0; valid_m = 1'b0; acc2_m = '0;
        for (int c = 0; c < 4; c++) acc_m[c] = '0;

        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        checkOutput("rst_idle", 128'(ap_idle), 128'd1);
        checkOutput("rst_done", 128'(ap_done), 128'd0);
        checkOutput("rst_ready", 128'(ap_ready), 128'd0);
        checkOutput("rst_o", o, 128'd0);
        checkOutput("rst_vld", 128'(o_ap_vld), 128'd0);
        checkOutput("rst_key_valid", 128'(key_valid), 128'd0);

        // Reset key (all zero) gives corrupted results.
        applyStimulus(1'b1, a_base, b_base, 1'b0);
        for (int c = 0; c < 4; c++)
            checkOutput($sformatf("nokey_diff%0d", c), 128'(o[c*32 +: 32] != 32'(gold_res[c])), 128'd1);
        checkOutput("nokey_valid", 128'(key_valid), 128'd0);

        // Golden key, overwrite then accumulate.
        loadKey(GOLD, 64, 1'b0);
        applyStimulus(1'b1, a_base, b_base, 1'b0);
        for (int c = 0; c < 4; c++)
            checkOutput($sformatf("gold_m1_ch%0d", c), 128'(o[c*32 +: 32]), 128'(gold_res[c]));
        applyStimulus(1'b0, a_base, b_base, 1'b0);
        for (int c = 0; c < 4; c++)
            checkOutput($sformatf("gold_m0_ch%0d", c), 128'(o[c*32 +: 32]), 128'(2 * gold_res[c]));
        applyStimulus(1'b0, {32'd5, 32'd4, 32'd3, 32'hFFFF_FFFF}, {32'd10, 32'd10, 32'd10, 32'd2}, 1'b0);
        checkOutput("wrap_ch0", 128'(o[31:0]), 128'd38);

        // Partial load, then a wrong key with the LSB flipped.
        loadKey(GOLD, 40, 1'b0);
        checkOutput("partial_invalid", 128'(key_valid), 128'd0);
        loadKey(GOLD ^ 64'd1, 64, 1'b0);
        applyStimulus(1'b1, a_base, b_base, 1'b0);
        checkOutput("wrongkey_ch0", 128'(o[31:0]), 128'd30);

        // Start and key_load together: the key load wins.
        loadKey(GOLD, 64, 1'b1);
        checkOutput("prio_key_valid", 128'(key_valid), 128'd1);

        // key_load during a run is ignored.
        applyStimulus(1'b1, a_base, b_base, 1'b1);
        applyStimulus(1'b1, a_base, b_base, 1'b0);
        checkOutput("runkey_ch1", 128'(o[63:32]), 128'd30);
        checkOutput("runkey_valid", 128'(key_valid), 128'd1);

        // Reset in the middle of a run.
        pushExpected(1'b0, a_base, b_base);
        ap_start = 1'b1; mode = 1'b0; i_a = a_base; i_b = b_base;
        @(negedge ap_clk);
        ap_start = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        exp_q.delete();
        key_m = '0; cnt_m = 0; valid_m = 1'b0; acc2_m = '0;
        for (int c = 0; c < 4; c++) acc_m[c] = '0;
        checkOutput("midrst_o", o, 128'd0);
        checkOutput("midrst_done", 128'(ap_done), 128'd0);
        checkOutput("midrst_idle", 128'(ap_idle), 128'd1);
        checkOutput("midrst_key_valid", 128'(key_valid), 128'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge ap_clk);
            checkOutput($sformatf("midrst_nodone%0d", k), 128'(ap_done | (|o_ap_vld)), 128'd0);
        end
        loadKey(GOLD, 64, 1'b0);
        applyStimulus(1'b0, a_base, b_base, 1'b0);
        for (int c = 0; c < 4; c++)
            checkOutput($sformatf("postrst_ch%0d", c), 128'(o[c*32 +: 32]), 128'(gold_res[c]));

        // Small instance: N_CH=1, DATA_W=8.
        key_load_s = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge ap_clk);
            key_bit_s = GOLD_S[15 - i];
        end
        @(negedge ap_clk);
        key_load_s = 1'b0;
        @(negedge ap_clk);
        checkOutput("sw_key_valid", 128'(key_valid_s), 128'd1);
        sweepRun(1'b1, 8'd16, 8'd16, 3);
        sweepRun(1'b1, 8'd3, 8'd5, 1);
        sweepRun(1'b0, 8'd3, 8'd5, 2);

        @(negedge ap_clk);
        checkOutput("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
